// File: rtl/ram2_master.sv
// ram2_master: bus initiator for a 32-word single-port RAM sharing one
// bidirectional data bus. Accepts read/write requests over valid/ready,
// sequences ena/wena/addr, drives the bus only in the write-issue cycle
// and captures registered read data one cycle after the read is issued.
// Every read is followed by an ena=0 cycle so the RAM has released the
// bus before the master can drive it again.
// Optional feature macro: RAM2_MASTER_VERIFY_EN (write read-back check).
module ram2_master #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_ena,
    output logic              mem_wena,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_CAPTURE   = 2'd2
`ifdef RAM2_MASTER_VERIFY_EN
        ,S_VERIFY_RD = 2'd3
`endif
    } state_t;

    state_t              r_state;
    state_t              w_state_n;

    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_drive;
    logic                r_mem_ena;
    logic                r_mem_wena;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    logic                w_hs;
    logic                w_mem_ena_n;
    logic                w_mem_wena_n;
    logic                w_drive_n;
    logic [ADDR_W-1:0]   w_mem_addr_n;
    logic                w_rsp_valid_n;
    logic [DATA_W-1:0]   w_rsp_rdata_n;
    logic                w_rsp_err_n;

    // Ready only in IDLE and never while reset is asserted.
    assign req_ready = (r_state == S_IDLE) && !rst;
    assign w_hs      = req_valid && req_ready;

    // The bus is driven from the latched write data under a registered enable.
    assign mem_data  = r_drive ? r_wdata : {DATA_W{1'bz}};

    assign mem_ena   = r_mem_ena;
    assign mem_wena  = r_mem_wena;
    assign mem_addr  = r_mem_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state logic: a read always passes through CAPTURE (ena=0).
    always_comb begin
        w_state_n = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_state_n = S_ISSUE;
                end else begin
                    w_state_n = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (r_we) begin
`ifdef RAM2_MASTER_VERIFY_EN
                    w_state_n = S_VERIFY_RD;
`else
                    w_state_n = S_IDLE;
`endif
                end else begin
                    w_state_n = S_CAPTURE;
                end
            end
`ifdef RAM2_MASTER_VERIFY_EN
            S_VERIFY_RD: w_state_n = S_CAPTURE;
`endif
            S_CAPTURE:   w_state_n = S_IDLE;
            default:     w_state_n = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, from the next state.
    always_comb begin
        w_mem_ena_n   = 1'b0;
        w_mem_wena_n  = 1'b0;
        w_drive_n     = 1'b0;
        w_mem_addr_n  = r_mem_addr;
        w_rsp_valid_n = 1'b0;
        w_rsp_rdata_n = r_rsp_rdata;
        w_rsp_err_n   = 1'b0;
        if (w_state_n == S_ISSUE) begin
            // ISSUE is entered only through a handshake, so req_* is current.
            w_mem_ena_n  = 1'b1;
            w_mem_wena_n = req_we;
            w_drive_n    = req_we;
            w_mem_addr_n = req_addr;
`ifdef RAM2_MASTER_VERIFY_EN
        end else if (w_state_n == S_VERIFY_RD) begin
            w_mem_ena_n  = 1'b1;
            w_mem_wena_n = 1'b0;
            w_mem_addr_n = r_mem_addr;
`endif
        end else begin
            w_mem_ena_n  = 1'b0;
        end
        if (r_state == S_CAPTURE) begin
            w_rsp_valid_n = 1'b1;
            w_rsp_rdata_n = mem_data;
`ifdef RAM2_MASTER_VERIFY_EN
            w_rsp_err_n   = r_we && (mem_data != r_wdata);
`endif
`ifndef RAM2_MASTER_VERIFY_EN
        end else if ((r_state == S_ISSUE) && r_we) begin
            w_rsp_valid_n = 1'b1;
`endif
        end else begin
            w_rsp_valid_n = 1'b0;
        end
    end

    // Request latch and registered bus/response outputs; reset drops any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_wdata     <= {DATA_W{1'b0}};
            r_drive     <= 1'b0;
            r_mem_ena   <= 1'b0;
            r_mem_wena  <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= {DATA_W{1'b0}};
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_hs) begin
                r_we    <= req_we;
                r_wdata <= req_wdata;
            end
            r_drive     <= w_drive_n;
            r_mem_ena   <= w_mem_ena_n;
            r_mem_wena  <= w_mem_wena_n;
            r_mem_addr  <= w_mem_addr_n;
            r_rsp_valid <= w_rsp_valid_n;
            r_rsp_rdata <= w_rsp_rdata_n;
            r_rsp_err   <= w_rsp_err_n;
        end
    end

endmodule

// File: tb/tb_ram2_master.sv
// Directed self-checking bench for ram2_master with a behavioural
// single-port RAM model on the shared bus.
module tb_ram2_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_ena;
    logic        mem_wena;
    logic [4:0]  mem_addr;
    wire  [31:0] mem_data;

    int n_checks = 0;
    int n_errors = 0;
    int conflict_cnt = 0;
    int bus_bad_cnt = 0;

`ifdef RAM2_MASTER_VERIFY_EN
    localparam int WR_LAT = 3;
`else
    localparam int WR_LAT = 1;
`endif

    ram2_master #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_ena(mem_ena), .mem_wena(mem_wena), .mem_addr(mem_addr),
        .mem_data(mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read that keeps driving until an ena=0 edge.
    logic [31:0] ram [0:31];
    logic        ram_drv;
    logic [31:0] ram_q;

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 32'h0000_0000;
        ram[31] = 32'h3131_3131;
        ram_drv = 1'b0;
        ram_q   = 32'h0000_0000;
    end

    always @(posedge clk) begin
        if (mem_ena) begin
            if (mem_wena) begin
`ifdef RAM2_MASTER_VERIFY_EN
                if (mem_addr == 5'd7) ram[mem_addr] <= mem_data & 32'hFFFF_FFFE;
                else                  ram[mem_addr] <= mem_data;
`else
                ram[mem_addr] <= mem_data;
`endif
            end else begin
                ram_drv <= 1'b1;
                ram_q   <= ram[mem_addr];
            end
        end else begin
            ram_drv <= 1'b0;
        end
    end

    assign mem_data = ram_drv ? ram_q : 32'hzzzz_zzzz;

    // Bus monitor: master write cycle while RAM still drives is contention.
    always @(negedge clk) begin
        if (ram_drv && mem_ena && mem_wena) conflict_cnt++;
        if (ram_drv && (mem_data !== ram_q)) bus_bad_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction from IDLE; returns response data/err and latency in edges after accept.
    task automatic xact(input logic we, input logic [4:0] a, input logic [31:0] d,
                        input int exp_lat, output logic [31:0] rd, output logic er);
        int lat;
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0;
        chk("issue_ena",   {31'd0, mem_ena},   32'd1);
        chk("issue_wena",  {31'd0, mem_wena},  {31'd0, we});
        chk("issue_addr",  {27'd0, mem_addr},  {27'd0, a});
        chk("issue_ready", {31'd0, req_ready}, 32'd0);
        if (we) chk("issue_data", mem_data, d);
        lat = 0;
        while (!rsp_valid && lat < 8) begin
            tick();
            lat++;
        end
        chk("latency", lat, exp_lat);
        rd = rsp_rdata;
        er = rsp_err;
        tick();
        chk("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          wr_seen;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 5'd0; req_wdata = 32'd0;
        tick();
        tick();
        chk("rst_ena",   {31'd0, mem_ena},   32'd0);
        chk("rst_wena",  {31'd0, mem_wena},  32'd0);
        chk("rst_addr",  {27'd0, mem_addr},  32'd0);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rdata", rsp_rdata,          32'd0);
        chk("rst_err",   {31'd0, rsp_err},   32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Write addr 5.
        xact(1'b1, 5'd5, 32'hDEAD_BEEF, WR_LAT, rd, er);
        chk("ram5", ram[5], 32'hDEAD_BEEF);
        chk("wr5_err", {31'd0, er}, 32'd0);
`ifdef RAM2_MASTER_VERIFY_EN
        chk("wr5_rdata", rd, 32'hDEAD_BEEF);
`else
        chk("wr5_rdata_hold", rd, 32'd0);
`endif

        // Read addr 5.
        xact(1'b0, 5'd5, 32'h0, 2, rd, er);
        chk("rd5", rd, 32'hDEAD_BEEF);
        chk("rd5_err", {31'd0, er}, 32'd0);

        // Read addr 31 then write addr 0 with req_valid held.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd31; req_wdata = 32'h0;
        tick();
        req_we = 1'b1; req_addr = 5'd0; req_wdata = 32'h1234_5678;
        wr_seen = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 2) begin
                chk("b2b_rvalid", {31'd0, rsp_valid}, 32'd1);
                chk("b2b_rdata",  rsp_rdata,          32'h3131_3131);
            end
            if (wr_seen == 0 && mem_ena && mem_wena) begin
                wr_seen = k;
                req_valid = 1'b0;
                chk("b2b_wdata", mem_data, 32'h1234_5678);
                chk("b2b_waddr", {27'd0, mem_addr}, 32'd0);
            end
        end
        chk("b2b_accept_edge", wr_seen, 3);
        chk("ram0", ram[0], 32'h1234_5678);

        // Boundary address write/read.
        xact(1'b1, 5'd31, 32'hA5A5_0F0F, WR_LAT, rd, er);
        chk("ram31", ram[31], 32'hA5A5_0F0F);
        xact(1'b0, 5'd31, 32'h0, 2, rd, er);
        chk("rd31", rd, 32'hA5A5_0F0F);

        // Reset during CAPTURE of a read.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd5;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_ena",   {31'd0, mem_ena},   32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd0);
        chk("midrst_rdata", rsp_rdata,          32'd0);
        rst = 1'b0;
        tick();
        chk("midrst_valid2", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_ramrel", {31'd0, ram_drv},   32'd0);
        xact(1'b0, 5'd5, 32'h0, 2, rd, er);
        chk("rd5_after_rst", rd, 32'hDEAD_BEEF);

`ifdef RAM2_MASTER_VERIFY_EN
        xact(1'b1, 5'd7, 32'h0000_000F, 3, rd, er);
        chk("vfy7_err",   {31'd0, er}, 32'd1);
        chk("vfy7_rdata", rd,          32'h0000_000E);
        xact(1'b1, 5'd8, 32'h0000_0055, 3, rd, er);
        chk("vfy8_err",   {31'd0, er}, 32'd0);
        chk("vfy8_rdata", rd,          32'h0000_0055);
`endif

        tick();
        chk("no_contention", conflict_cnt, 0);
        chk("bus_value",     bus_bad_cnt,  0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram2_master.md
# ram2_master

Bus initiator for the 32-word single-port RAM with a shared bidirectional data bus. Accepts read and write requests from core logic through a valid/ready handshake and sequences `ena`/`wena`/`addr` onto the RAM. Drives `data` only during write cycles and captures registered read data one cycle after issue. Guarantees the RAM has released the bus before the master drives it. Sits between the datapath/control unit and the RAM instance in the memory subsystem.

## Interface
- `ADDR_W`, default 5: RAM address width.
- `DATA_W`, default 32: RAM data width.

- `clk`  in  1  rising-edge clock, shared with RAM.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  master can accept a request this cycle.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  one-cycle pulse: transaction complete.
- `rsp_rdata`  out  DATA_W  read data; holds last captured value between reads.
- `rsp_err`  out  1  read-back mismatch, qualified by `rsp_valid` (see Configuration).
- `mem_ena`  out  1  RAM enable.
- `mem_wena`  out  1  RAM write enable.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_data`  inout  DATA_W  shared data bus; master drives only in the write-issue cycle, else high-Z.

## Operation
- RAM contract: at an edge with `ena=1, wena=1` it stores `data`. At an edge with `ena=1, wena=0` it begins driving `ram[addr]` after the edge and keeps driving it; a write does not release the bus. At an edge with `ena=0` it releases the bus.
- The master releases the RAM bus before every write by always following a read with an `ena=0` cycle.
- All `mem_*` outputs, `rsp_*` outputs and the tristate enable are registered.
- States:
  - IDLE: `req_ready=1`, `mem_ena=0`. Handshake (`req_valid & req_ready`) latches `req_we`, `req_addr` and `req_wdata`, then moves to ISSUE.
  - ISSUE: `mem_ena=1`, `mem_wena=we`, `mem_addr=addr`. Master drives `mem_data=wdata` only if `we=1`.
    - Write: next state IDLE, `rsp_valid` pulses.
    - Read: next state CAPTURE.
  - CAPTURE: `mem_ena=0`, master not driving. The next edge samples `mem_data` into `rsp_rdata`, pulses `rsp_valid` and moves to IDLE. The RAM releases the bus at the same edge.
- `req_ready` is 0 in every state except IDLE, and is forced 0 while `rst=1`.
- `rsp_valid` has no backpressure; the consumer must accept the pulse.

## Timing
- E0 = accept edge.
- Write: ISSUE cycle E0–E1; RAM writes at E1; `rsp_valid` high E1–E2; `req_ready` high again after E1. Throughput is 1 write per 2 cycles.
- Read: ISSUE E0–E1; CAPTURE E1–E2; `rsp_valid` and new `rsp_rdata` after E2. Throughput is 1 read per 3 cycles.
- Back-to-back requests with `req_valid` held are accepted at the first IDLE edge; no extra bubble.
- Reset values: state IDLE, `mem_ena=0`, `mem_wena=0`, `mem_addr=0`, `mem_data` high-Z, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`.
- At least one reset clock is required; it forces the RAM to release the bus.
- Reset mid-operation: the in-flight transaction is dropped and no `rsp_valid` is issued.
  - If `rst` is sampled at the ISSUE-ending edge, the RAM still performs that access, since the RAM has no reset.
  - Bus is high-Z from both sides after the following edge.
- Address is used as-is; no wrap logic. `ADDR_W` bits address exactly 2^ADDR_W words.

## Configuration
- `RAM2_MASTER_VERIFY_EN` defined:
  - Each write proceeds ISSUE → VERIFY_RD (`mem_ena=1`, `mem_wena=0`, same addr) → CAPTURE.
  - Captured data is compared with the latched wdata.
  - `rsp_valid` pulses after the CAPTURE edge (write latency 3 cycles), with `rsp_err=1` on mismatch.
  - `rsp_rdata` updates to the read-back value.
- Undefined: VERIFY_RD state is absent, write latency is 1 cycle, and `rsp_err` is constant 0.

## Test plan
- Reset: `rst=1` for 2 cycles → `mem_ena=0`, `mem_data`=Z from master, `rsp_valid=0`, `req_ready=0`; one cycle after release `req_ready=1`.
- Write addr 5 = 0xDEADBEEF → one cycle with `mem_ena=1`, `mem_wena=1`, `mem_addr=5`, `mem_data=0xDEADBEEF`; `rsp_valid` one cycle later; RAM word 5 = 0xDEADBEEF.
- Read addr 5 → `rsp_valid` 2 edges after accept with `rsp_rdata=0xDEADBEEF`; master never drives `mem_data`.
- Read addr 31, then write addr 0 = 0x12345678 with `req_valid` held → `mem_data` never X (no contention); write accepted 3 edges after the read; RAM word 0 = 0x12345678.
- `rst` pulsed during CAPTURE of a read → no `rsp_valid`; bus Z; a subsequent read of addr 5 returns 0xDEADBEEF.
- With `RAM2_MASTER_VERIFY_EN`, bench RAM model corrupts bit 0 on write to addr 7 of 0x0000000F → `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0x0000000E`; an uncorrupted write gives `rsp_err=0`.
